// File: rtl/dram_lookup_arbiter.sv
// Round-robin arbiter sharing one DRAM read channel among the AES byte-lookup lanes.
// One grant = one read transaction; the byte goes back only to the granted lane.
module dram_lookup_arbiter #(
    parameter int N_REQ   = 16,
    parameter int RWL_W   = 6,
    parameter int DMX_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*RWL_W-1:0]   req_rwl,
    input  logic [N_REQ*DMX_W-1:0]   req_dmx,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rsp_vld,
    output logic [7:0]               rsp_data,
    output logic                     rd_start,
    output logic [RWL_W-1:0]         rd_rwl,
    output logic [DMX_W-1:0]         rd_dmx,
    output logic [$clog2(N_REQ)-1:0] rd_core,
    input  logic                     rd_done,
    input  logic [7:0]               rd_data,
    input  logic                     clr_err,
    output logic                     busy,
    output logic                     timeout_err,
    output logic [1:0]               dbg_state
);
    localparam int IDX_W  = $clog2(N_REQ);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    // Handshake: rd_start is a one-cycle command; rd_done is honoured only in WAIT,
    // rsp_vld is a one-cycle one-hot strobe with rsp_data held until the next response.
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state, state_n;
    logic [IDX_W-1:0]  ptr;
    logic [WCNT_W-1:0] wcnt;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic              wcnt_hit;

    // Winner is the first set request at or after ptr, wrapping round.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && req[(int'(ptr) + i) % N_REQ]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(ptr) + i) % N_REQ);
            end
        end
    end

    assign wcnt_hit = (wcnt == WCNT_W'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (EN && win_found) state_n = S_ISSUE;
            S_ISSUE: state_n = S_WAIT;
            S_WAIT:  if (rd_done || wcnt_hit) state_n = S_RESP;
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr         <= '0;
            wcnt        <= '0;
            gnt         <= '0;
            rsp_data    <= '0;
            rd_rwl      <= '0;
            rd_dmx      <= '0;
            rd_core     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (clr_err) timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (EN && win_found) begin
                        rd_core <= win_idx;
                        rd_rwl  <= req_rwl[int'(win_idx)*RWL_W +: RWL_W];
                        rd_dmx  <= req_dmx[int'(win_idx)*DMX_W +: DMX_W];
                        gnt     <= N_REQ'(1) << win_idx;
                    end
                end
                S_ISSUE: wcnt <= '0;
                S_WAIT: begin
                    wcnt <= wcnt + 1'b1;
                    // A completing read beats a coincident timeout.
                    if (rd_done) begin
                        rsp_data <= rd_data;
                    end else if (wcnt_hit) begin
                        rsp_data    <= 8'h00;
                        timeout_err <= 1'b1;
                    end
                end
                S_RESP: begin
                    gnt <= '0;
                    ptr <= (int'(rd_core) == N_REQ - 1) ? '0 : rd_core + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_vld   = (state == S_RESP) ? gnt : '0;
    assign rd_start  = (state == S_ISSUE);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;
endmodule

// File: tb/tb_dram_lookup_arbiter.sv
// Directed bench for dram_lookup_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_dram_lookup_arbiter;
    logic        CLK, RST, EN;
    logic [15:0] req;
    logic [95:0] req_rwl;
    logic [47:0] req_dmx;
    logic [15:0] gnt, rsp_vld;
    logic [7:0]  rsp_data;
    logic        rd_start;
    logic [5:0]  rd_rwl;
    logic [2:0]  rd_dmx;
    logic [3:0]  rd_core;
    logic        rd_done;
    logic [7:0]  rd_data;
    logic        clr_err, busy, timeout_err;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    logic [5:0] exp_rwl [16];
    logic [2:0] exp_dmx [16];

    dram_lookup_arbiter #(.N_REQ(16), .RWL_W(6), .DMX_W(3), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .req(req), .req_rwl(req_rwl), .req_dmx(req_dmx),
        .gnt(gnt), .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rd_start(rd_start),
        .rd_rwl(rd_rwl), .rd_dmx(rd_dmx), .rd_core(rd_core), .rd_done(rd_done),
        .rd_data(rd_data), .clr_err(clr_err), .busy(busy), .timeout_err(timeout_err),
        .dbg_state(dbg_state)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got no end of test, want end before 200000");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic do_reset();
        RST = 1'b1; EN = 1'b0; req = '0; rd_done = 1'b0; clr_err = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Drives one complete transaction from IDLE with rd_done in the first WAIT cycle.
    task automatic run_txn(input logic [15:0] r, input logic [7:0] d,
                           output logic st, output logic [3:0] core, output logic [5:0] rwl,
                           output logic [2:0] dmx, output logic [15:0] rsp, output logic [7:0] data);
        req = r; EN = 1'b1;
        @(negedge CLK);
        st = rd_start; core = rd_core; rwl = rd_rwl; dmx = rd_dmx;
        @(negedge CLK);
        rd_done = 1'b1; rd_data = d;
        @(negedge CLK);
        rd_done = 1'b0;
        rsp = rsp_vld; data = rsp_data;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1; EN = 1'b1; req = 16'hFFFF; rd_done = 1'b1; rd_data = 8'hEE; clr_err = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++; if (gnt !== 16'h0) begin errors++; $display("FAIL reset_gnt: got %h want 0", gnt); end
        checks++; if (rsp_vld !== 16'h0) begin errors++; $display("FAIL reset_rsp_vld: got %h want 0", rsp_vld); end
        checks++; if (rsp_data !== 8'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        checks++; if ({rd_start, rd_rwl, rd_dmx, rd_core} !== 14'h0) begin errors++; $display("FAIL reset_rd: got %h want 0", {rd_start, rd_rwl, rd_dmx, rd_core}); end
        checks++; if ({busy, timeout_err, dbg_state} !== 4'h0) begin errors++; $display("FAIL reset_status: got %h want 0", {busy, timeout_err, dbg_state}); end
        RST = 1'b0; req = '0; rd_done = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_single();
        req = 16'h0004; EN = 1'b1;
        @(negedge CLK);
        checks++; if (gnt !== 16'h0004) begin errors++; $display("FAIL single_gnt: got %h want 0004", gnt); end
        checks++; if ({busy, rd_start} !== 2'b11) begin errors++; $display("FAIL single_start: got %b want 11", {busy, rd_start}); end
        checks++; if (rd_rwl !== 6'd17) begin errors++; $display("FAIL single_rwl: got %0d want 17", rd_rwl); end
        checks++; if (rd_dmx !== 3'd5) begin errors++; $display("FAIL single_dmx: got %0d want 5", rd_dmx); end
        checks++; if (rd_core !== 4'd2) begin errors++; $display("FAIL single_core: got %0d want 2", rd_core); end
        // Request dropped after the latch and a stray rd_done during ISSUE.
        req = 16'h0000; rd_done = 1'b1; rd_data = 8'h11;
        @(negedge CLK);
        checks++; if ({busy, rd_start, rsp_vld} !== {2'b10, 16'h0}) begin errors++; $display("FAIL single_wait: got %h want %h", {busy, rd_start, rsp_vld}, {2'b10, 16'h0}); end
        rd_done = 1'b1; rd_data = 8'hA5;
        @(negedge CLK);
        rd_done = 1'b0;
        checks++; if (rsp_vld !== 16'h0004) begin errors++; $display("FAIL single_rsp_vld: got %h want 0004", rsp_vld); end
        checks++; if (rsp_data !== 8'hA5) begin errors++; $display("FAIL single_rsp_data: got %h want a5", rsp_data); end
        checks++; if ({rd_rwl, rd_dmx, rd_core} !== {6'd17, 3'd5, 4'd2}) begin errors++; $display("FAIL single_hold: got %h want %h", {rd_rwl, rd_dmx, rd_core}, {6'd17, 3'd5, 4'd2}); end
        @(negedge CLK);
        checks++; if ({gnt, rsp_vld, busy} !== 33'h0) begin errors++; $display("FAIL single_idle: got %h want 0", {gnt, rsp_vld, busy}); end
        checks++; if ({rsp_data, rd_rwl, rd_core} !== {8'hA5, 6'd17, 4'd2}) begin errors++; $display("FAIL single_retain: got %h want %h", {rsp_data, rd_rwl, rd_core}, {8'hA5, 6'd17, 4'd2}); end
    endtask

    task automatic test_stray_idle();
        req = '0; rd_done = 1'b1; rd_data = 8'h77;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            checks++; if ({busy, rsp_vld, rsp_data} !== {1'b0, 16'h0, 8'hA5}) begin errors++; $display("FAIL stray_idle_%0d: got %h want %h", c, {busy, rsp_vld, rsp_data}, {1'b0, 16'h0, 8'hA5}); end
        end
        rd_done = 1'b0;
    endtask

    task automatic test_round_robin();
        logic st; logic [3:0] core; logic [5:0] rwl; logic [2:0] dmx; logic [15:0] rsp; logic [7:0] data;
        int seen [16];
        for (int i = 0; i < 16; i++) seen[i] = 0;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            run_txn(16'hFFFF, 8'(i * 7 + 1), st, core, rwl, dmx, rsp, data);
            if (i < 16) seen[core]++;
            checks++; if (core !== 4'(i % 16)) begin errors++; $display("FAIL rr_core_%0d: got %0d want %0d", i, core, i % 16); end
            checks++; if ({st, rwl, dmx} !== {1'b1, exp_rwl[i % 16], exp_dmx[i % 16]}) begin errors++; $display("FAIL rr_addr_%0d: got %h want %h", i, {st, rwl, dmx}, {1'b1, exp_rwl[i % 16], exp_dmx[i % 16]}); end
            checks++; if (rsp !== (16'h1 << (i % 16)) || data !== 8'(i * 7 + 1)) begin errors++; $display("FAIL rr_rsp_%0d: got %h/%h want %h/%h", i, rsp, data, 16'h1 << (i % 16), 8'(i * 7 + 1)); end
        end
        for (int i = 0; i < 16; i++) begin
            checks++; if (seen[i] != 1) begin errors++; $display("FAIL rr_fair_%0d: got %0d grants want 1", i, seen[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int starts = 0, rsps = 0;
        logic [3:0] order [$];
        req = 16'hFFFF; EN = 1'b1; rd_done = 1'b1; rd_data = 8'hC3;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (rd_start) begin starts++; order.push_back(rd_core); end
            if (rsp_vld != 16'h0) rsps++;
        end
        req = '0; rd_done = 1'b0;
        checks++; if (starts != 3 || rsps != 3) begin errors++; $display("FAIL b2b_rate: got %0d/%0d want 3/3", starts, rsps); end
        checks++; if (order.size() != 3 || order[0] !== 4'd1 || order[1] !== 4'd2 || order[2] !== 4'd3) begin errors++; $display("FAIL b2b_order: got %p want 1,2,3", order); end
        checks++; if (rsp_data !== 8'hC3) begin errors++; $display("FAIL b2b_data: got %h want c3", rsp_data); end
    endtask

    task automatic test_wrap();
        logic st; logic [3:0] core; logic [5:0] rwl; logic [2:0] dmx; logic [15:0] rsp; logic [7:0] data;
        do_reset();
        run_txn(16'h2000, 8'h01, st, core, rwl, dmx, rsp, data);
        checks++; if (core !== 4'd13) begin errors++; $display("FAIL wrap_setup: got %0d want 13", core); end
        run_txn(16'h0003, 8'h02, st, core, rwl, dmx, rsp, data);
        checks++; if (core !== 4'd0 || rsp !== 16'h0001) begin errors++; $display("FAIL wrap_first: got %0d/%h want 0/0001", core, rsp); end
        run_txn(16'h0003, 8'h03, st, core, rwl, dmx, rsp, data);
        checks++; if (core !== 4'd1 || rsp !== 16'h0002) begin errors++; $display("FAIL wrap_second: got %0d/%h want 1/0002", core, rsp); end
        run_txn(16'hFFFF, 8'h04, st, core, rwl, dmx, rsp, data);
        checks++; if (core !== 4'd2) begin errors++; $display("FAIL wrap_ptr: got %0d want 2", core); end
        req = '0;
    endtask

    task automatic test_gating();
        logic st; logic [3:0] core; logic [5:0] rwl; logic [2:0] dmx; logic [15:0] rsp; logic [7:0] data;
        EN = 1'b0; req = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            checks++; if ({gnt, busy, rd_start} !== 18'h0) begin errors++; $display("FAIL gate_%0d: got %h want 0", c, {gnt, busy, rd_start}); end
        end
        run_txn(16'hFFFF, 8'h5A, st, core, rwl, dmx, rsp, data);
        checks++; if (core !== 4'd3 || data !== 8'h5A) begin errors++; $display("FAIL gate_ptr: got %0d/%h want 3/5a", core, data); end
        req = '0;
    endtask

    task automatic test_timeout();
        // Plain timeout on requester 0 (ptr is 4, so the search wraps).
        req = 16'h0001; EN = 1'b1;
        @(negedge CLK);
        checks++; if (rd_start !== 1'b1 || rd_core !== 4'd0) begin errors++; $display("FAIL to_issue: got %b/%0d want 1/0", rd_start, rd_core); end
        req = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            checks++; if ({busy, rsp_vld, timeout_err} !== {1'b1, 16'h0, 1'b0}) begin errors++; $display("FAIL to_wait_%0d: got %h want %h", c, {busy, rsp_vld, timeout_err}, {1'b1, 16'h0, 1'b0}); end
        end
        @(negedge CLK);
        checks++; if ({rsp_vld, rsp_data, timeout_err} !== {16'h0001, 8'h00, 1'b1}) begin errors++; $display("FAIL to_resp: got %h want %h", {rsp_vld, rsp_data, timeout_err}, {16'h0001, 8'h00, 1'b1}); end
        @(negedge CLK);
        checks++; if ({busy, rsp_data, timeout_err} !== {1'b0, 8'h00, 1'b1}) begin errors++; $display("FAIL to_after: got %h want %h", {busy, rsp_data, timeout_err}, {1'b0, 8'h00, 1'b1}); end
        clr_err = 1'b1;
        @(negedge CLK);
        clr_err = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", timeout_err); end
        // clr_err held across a second timeout: the set in the last WAIT cycle wins.
        req = 16'h0002; clr_err = 1'b1;
        @(negedge CLK);
        req = '0;
        for (int c = 0; c < 5; c++) @(negedge CLK);
        checks++; if ({rsp_vld, timeout_err} !== {16'h0002, 1'b1}) begin errors++; $display("FAIL to_set_wins: got %h want %h", {rsp_vld, timeout_err}, {16'h0002, 1'b1}); end
        @(negedge CLK);
        clr_err = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear2: got %b want 0", timeout_err); end
        // rd_done in the last WAIT cycle beats the timeout.
        req = 16'h0004;
        @(negedge CLK);
        req = '0;
        for (int c = 0; c < 3; c++) @(negedge CLK);
        @(negedge CLK);
        rd_done = 1'b1; rd_data = 8'h3C;
        @(negedge CLK);
        rd_done = 1'b0;
        checks++; if ({rsp_vld, rsp_data, timeout_err} !== {16'h0004, 8'h3C, 1'b0}) begin errors++; $display("FAIL to_done_wins: got %h want %h", {rsp_vld, rsp_data, timeout_err}, {16'h0004, 8'h3C, 1'b0}); end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        logic st; logic [3:0] core; logic [5:0] rwl; logic [2:0] dmx; logic [15:0] rsp; logic [7:0] data;
        req = 16'h0100; EN = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL rm_in_wait: got %0d want 2", dbg_state); end
        RST = 1'b1; rd_done = 1'b1; rd_data = 8'h99;
        @(negedge CLK);
        RST = 1'b0; rd_done = 1'b0; req = '0;
        checks++; if ({gnt, rsp_vld, rsp_data, rd_start, rd_rwl, rd_dmx, rd_core, busy, timeout_err} !== 55'h0) begin errors++; $display("FAIL rm_outputs: got %h want 0", {gnt, rsp_vld, rsp_data, rd_start, rd_rwl, rd_dmx, rd_core, busy, timeout_err}); end
        @(negedge CLK);
        checks++; if ({rsp_vld, busy} !== 17'h0) begin errors++; $display("FAIL rm_no_rsp: got %h want 0", {rsp_vld, busy}); end
        run_txn(16'hFFFF, 8'h42, st, core, rwl, dmx, rsp, data);
        checks++; if (core !== 4'd0 || data !== 8'h42) begin errors++; $display("FAIL rm_ptr: got %0d/%h want 0/42", core, data); end
        req = '0;
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; req = '0; rd_done = 1'b0; rd_data = '0; clr_err = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_rwl[i] = (i == 2) ? 6'd17 : 6'((i * 5 + 3) % 64);
            exp_dmx[i] = (i == 2) ? 3'd5 : 3'((i * 3 + 1) % 8);
            req_rwl[i*6 +: 6] = exp_rwl[i];
            req_dmx[i*3 +: 3] = exp_dmx[i];
        end
        @(negedge CLK);
        test_reset();
        test_single();
        test_stray_idle();
        test_round_robin();
        test_back_to_back();
        test_wrap();
        test_gating();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
